// File: rtl/timestamp_pkg.sv
// Shared constants for the timestamp readout: FSM encoding,
// frame word indices and header field layout.
package timestamp_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CAPTURE  = 3'd1;
  localparam logic [2:0] ST_HDR      = 3'd2;
  localparam logic [2:0] ST_LO       = 3'd3;
  localparam logic [2:0] ST_HI       = 3'd4;
  localparam logic [2:0] ST_PH       = 3'd5;
  localparam logic [2:0] ST_RST      = 3'd6;
  localparam logic [2:0] ST_WAIT_CLR = 3'd7;

  localparam logic [1:0] WORD_HDR = 2'd0;
  localparam logic [1:0] WORD_LO  = 2'd1;
  localparam logic [1:0] WORD_HI  = 2'd2;
  localparam logic [1:0] WORD_PH  = 2'd3;
  localparam int FRAME_WORDS = 4;

  localparam logic [7:0] MARKER_DEFAULT = 8'hA5;

  localparam int HDR_MARK_MSB = 31;
  localparam int HDR_MARK_LSB = 24;
  localparam int HDR_CH_BIT   = 16;
  localparam int HDR_SEQ_MSB  = 15;

  // Phase is 26 bits wide; the upper bits of the word are zero.
  localparam logic [31:0] PHASE_MASK = 32'h03FF_FFFF;

  function automatic logic [31:0] makeHeader(
    input logic [7:0]  marker,
    input logic        ch,
    input logic [15:0] seq
  );
    logic [31:0] h;
    h = '0;
    h[HDR_MARK_MSB:HDR_MARK_LSB] = marker;
    h[HDR_CH_BIT] = ch;
    h[HDR_SEQ_MSB:0] = seq;
    return h;
  endfunction

endpackage

// File: rtl/timestamp_readout_sync.sv
// sync_bit: async-reset flip-flop chain bringing one flag into the
// clock domain. Ports: clk, rst (active high), d (async), q (synced).
module sync_bit #(
  parameter int pSTAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [pSTAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[pSTAGES-2:0], d};
  end

  assign q = chain[pSTAGES-1];

endmodule

// File: rtl/timestamp_readout.sv
// timestamp_readout: captures latched count/phase per channel and
// streams 4-word frames (hdr, lo, hi, phase) on valid/ready.
// Ports: globalClock, iReset; per channel iRdyN, iNLo/Hi/Phase,
// oResetLatchN; stream oData/oValid/iReady/oLast; status oBusy.
module timestamp_readout
  import timestamp_pkg::*;
#(
  parameter int         pSYNC_STAGES = 2,
  parameter logic [7:0] pMARKER      = MARKER_DEFAULT,
  parameter int         pRST_PULSE   = 1
) (
  input  logic        globalClock,
  input  logic        iReset,
  input  logic        iRdy1,
  input  logic [31:0] i1Lo,
  input  logic [31:0] i1Hi,
  input  logic [31:0] i1Phase,
  input  logic        iRdy2,
  input  logic [31:0] i2Lo,
  input  logic [31:0] i2Hi,
  input  logic [31:0] i2Phase,
  output logic        oResetLatch1,
  output logic        oResetLatch2,
  output logic [31:0] oData,
  output logic        oValid,
  input  logic        iReady,
  output logic        oLast,
  output logic        oBusy
);

  localparam logic [3:0] RST_LAST = 4'(pRST_PULSE - 1);

  logic        rdy1S;
  logic        rdy2S;
  logic [2:0]  state;
  logic        selCh;
  logic        rrPtr;
  logic [31:0] holdLo;
  logic [31:0] holdHi;
  logic [31:0] holdPh;
  logic [15:0] seq1;
  logic [15:0] seq2;
  logic [3:0]  rstCnt;
  logic        accept;
  logic        selRdy;

  sync_bit #(.pSTAGES(pSYNC_STAGES)) uSync1 (
    .clk (globalClock),
    .rst (iReset),
    .d   (iRdy1),
    .q   (rdy1S)
  );

  sync_bit #(.pSTAGES(pSYNC_STAGES)) uSync2 (
    .clk (globalClock),
    .rst (iReset),
    .d   (iRdy2),
    .q   (rdy2S)
  );

  assign accept = oValid && iReady;
  assign selRdy = selCh ? rdy2S : rdy1S;

  always_ff @(posedge globalClock or posedge iReset) begin
    if (iReset) begin
      state  <= ST_IDLE;
      selCh  <= 1'b0;
      rrPtr  <= 1'b0;
      holdLo <= '0;
      holdHi <= '0;
      holdPh <= '0;
      seq1   <= '0;
      seq2   <= '0;
      rstCnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rdy1S || rdy2S) begin
            state <= ST_CAPTURE;
            // Tie goes to the pointer, which then flips so the
            // other channel wins the next tie.
            if (rdy1S && rdy2S) begin
              selCh <= rrPtr;
              rrPtr <= ~rrPtr;
            end else begin
              selCh <= rdy2S;
            end
          end
        end
        ST_CAPTURE: begin
          if (selCh) begin
            holdLo <= i2Lo;
            holdHi <= i2Hi;
            holdPh <= i2Phase;
          end else begin
            holdLo <= i1Lo;
            holdHi <= i1Hi;
            holdPh <= i1Phase;
          end
          state <= ST_HDR;
        end
        ST_HDR: if (accept) state <= ST_LO;
        ST_LO:  if (accept) state <= ST_HI;
        ST_HI:  if (accept) state <= ST_PH;
        ST_PH: begin
          if (accept) begin
            if (selCh) seq2 <= seq2 + 16'd1;
            else       seq1 <= seq1 + 16'd1;
            rstCnt <= '0;
            state  <= ST_RST;
          end
        end
        ST_RST: begin
          if (rstCnt == RST_LAST) state <= ST_WAIT_CLR;
          else                    rstCnt <= rstCnt + 4'd1;
        end
        ST_WAIT_CLR: begin
          // The latch stays set until its reset resolves; resending
          // before it clears would duplicate the frame.
          if (!selRdy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    oData  = '0;
    oLast  = 1'b0;
    oValid = 1'b0;
    unique case (state)
      ST_HDR: begin
        oValid = 1'b1;
        oData  = makeHeader(pMARKER, selCh, selCh ? seq2 : seq1);
      end
      ST_LO: begin
        oValid = 1'b1;
        oData  = holdLo;
      end
      ST_HI: begin
        oValid = 1'b1;
        oData  = holdHi;
      end
      ST_PH: begin
        oValid = 1'b1;
        oLast  = 1'b1;
        oData  = holdPh & PHASE_MASK;
      end
      default: ;
    endcase
  end

  assign oResetLatch1 = (state == ST_RST) && !selCh;
  assign oResetLatch2 = (state == ST_RST) &&  selCh;
  assign oBusy        = (state != ST_IDLE);

endmodule

// File: tb/tb_timestamp_readout.sv
// Scoreboard bench for timestamp_readout: expected words queued
// at stimulus time, popped and compared as the stream accepts.
module tb_timestamp_readout;

  localparam int RSTW = 1;

  logic        globalClock = 1'b0;
  logic        iReset;
  logic        iRdy1, iRdy2;
  logic [31:0] i1Lo, i1Hi, i1Phase;
  logic [31:0] i2Lo, i2Hi, i2Phase;
  logic        oResetLatch1, oResetLatch2;
  logic [31:0] oData;
  logic        oValid;
  logic        iReady;
  logic        oLast;
  logic        oBusy;

  timestamp_readout dut (
    .globalClock  (globalClock),
    .iReset       (iReset),
    .iRdy1        (iRdy1),
    .i1Lo         (i1Lo),
    .i1Hi         (i1Hi),
    .i1Phase      (i1Phase),
    .iRdy2        (iRdy2),
    .i2Lo         (i2Lo),
    .i2Hi         (i2Hi),
    .i2Phase      (i2Phase),
    .oResetLatch1 (oResetLatch1),
    .oResetLatch2 (oResetLatch2),
    .oData        (oData),
    .oValid       (oValid),
    .iReady       (iReady),
    .oLast        (oLast),
    .oBusy        (oBusy)
  );

  always #5 globalClock = ~globalClock;

  int total = 0;
  int bad = 0;
  logic [32:0] expQ[$];
  logic [15:0] mSeq1, mSeq2;
  logic mPtr;
  int accepts = 0;
  int rl1Cycles = 0, rl2Cycles = 0;
  int expRl1 = 0, expRl2 = 0;
  int rdyMode = 0;
  int rdyPh = 0;
  logic stallPrev = 1'b0;
  logic [32:0] stallWord;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic pushFrame(input logic ch, input logic [31:0] lo,
                           input logic [31:0] hi, input logic [31:0] ph,
                           input logic [15:0] seq);
    expQ.push_back({1'b0, 8'hA5, 7'b0, ch, seq});
    expQ.push_back({1'b0, lo});
    expQ.push_back({1'b0, hi});
    expQ.push_back({1'b1, 6'b0, ph[25:0]});
  endtask

  task automatic setData(input logic ch, input logic [31:0] lo,
                         input logic [31:0] hi, input logic [31:0] ph);
    if (ch) begin
      i2Lo = lo; i2Hi = hi; i2Phase = ph;
    end else begin
      i1Lo = lo; i1Hi = hi; i1Phase = ph;
    end
  endtask

  task automatic waitPulse(input logic ch, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge globalClock);
      if (ch ? oResetLatch2 : oResetLatch1) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'(1));
  endtask

  task automatic bumpSeq(input logic ch);
    if (ch) begin mSeq2 = mSeq2 + 16'd1; expRl2 += RSTW; end
    else    begin mSeq1 = mSeq1 + 16'd1; expRl1 += RSTW; end
  endtask

  task automatic setRdy(input logic ch, input logic v);
    if (ch) iRdy2 = v;
    else    iRdy1 = v;
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 200 && expQ.size() != 0; i++)
      @(negedge globalClock);
    repeat (8) @(negedge globalClock);
    check({tag, "_q"}, 64'(expQ.size()), 64'(0));
    check({tag, "_busy"}, 64'(oBusy), 64'(0));
  endtask

  task automatic sendFrame(input logic ch, input logic [31:0] lo,
                           input logic [31:0] hi, input logic [31:0] ph,
                           input string tag);
    setData(ch, lo, hi, ph);
    @(posedge globalClock); #1;
    pushFrame(ch, lo, hi, ph, ch ? mSeq2 : mSeq1);
    setRdy(ch, 1'b1);
    waitPulse(ch, {tag, "_pulse"});
    bumpSeq(ch);
    setRdy(ch, 1'b0);
    settle(tag);
  endtask

  task automatic sendBoth(input logic [31:0] lo1, input logic [31:0] lo2,
                          input string tag);
    logic first;
    setData(1'b0, lo1, 32'h11, 32'h0111_1111);
    setData(1'b1, lo2, 32'h22, 32'h0222_2222);
    @(posedge globalClock); #1;
    first = mPtr;
    if (!first) begin
      pushFrame(1'b0, lo1, 32'h11, 32'h0111_1111, mSeq1);
      pushFrame(1'b1, lo2, 32'h22, 32'h0222_2222, mSeq2);
    end else begin
      pushFrame(1'b1, lo2, 32'h22, 32'h0222_2222, mSeq2);
      pushFrame(1'b0, lo1, 32'h11, 32'h0111_1111, mSeq1);
    end
    iRdy1 = 1'b1;
    iRdy2 = 1'b1;
    waitPulse(first, {tag, "_p1"});
    bumpSeq(first);
    setRdy(first, 1'b0);
    waitPulse(!first, {tag, "_p2"});
    bumpSeq(!first);
    setRdy(!first, 1'b0);
    mPtr = !mPtr;
    settle(tag);
  endtask

  initial begin
    forever begin
      @(posedge globalClock); #1;
      if (rdyMode == 0) begin
        iReady = 1'b1;
      end else if (rdyMode == 1) begin
        iReady = (rdyPh == 0);
        rdyPh = (rdyPh + 1) % 3;
      end
    end
  end

  initial begin
    logic [32:0] w;
    forever begin
      @(negedge globalClock);
      if (oResetLatch1) rl1Cycles++;
      if (oResetLatch2) rl2Cycles++;
      if (iReset) begin
        stallPrev = 1'b0;
      end else begin
        if (stallPrev)
          check("hold", 64'({oValid, oLast, oData}),
                64'({1'b1, stallWord}));
        if (oValid && iReady) begin
          accepts++;
          if (expQ.size() == 0) begin
            check("extra", 64'({1'b1, oLast, oData}), 64'(0));
          end else begin
            w = expQ.pop_front();
            check("word", 64'({oLast, oData}), 64'(w));
          end
        end
        stallPrev = oValid && !iReady;
        stallWord = {oLast, oData};
      end
    end
  end

  initial begin
    int n;
    int heldValid;
    int acc0;
    iReset = 1'b1;
    iRdy1 = 1'b0; iRdy2 = 1'b0;
    iReady = 1'b0;
    setData(1'b0, '0, '0, '0);
    setData(1'b1, '0, '0, '0);
    mSeq1 = '0; mSeq2 = '0; mPtr = 1'b0;
    repeat (3) @(posedge globalClock);
    #1;
    check("rst_out", 64'({oValid, oLast, oBusy, oResetLatch1,
                          oResetLatch2}), 64'(0));
    check("rst_data", 64'(oData), 64'(0));
    iReset = 1'b0;
    repeat (2) @(posedge globalClock);

    // Single capture with latency measurement.
    setData(1'b0, 32'h0000_1234, 32'h0000_0001, 32'h03FF_FFFF);
    @(posedge globalClock); #1;
    pushFrame(1'b0, 32'h0000_1234, 32'h0000_0001, 32'h03FF_FFFF, mSeq1);
    iRdy1 = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && !oValid; i++) begin
      @(negedge globalClock);
      n++;
    end
    check("latency", 64'(n), 64'(5));
    waitPulse(1'b0, "single_pulse");
    bumpSeq(1'b0);
    iRdy1 = 1'b0;
    settle("single");
    check("single_rl1", 64'(rl1Cycles), 64'(expRl1));

    // Backpressure 1,0,0 pattern.
    rdyMode = 1;
    rdyPh = 0;
    acc0 = accepts;
    sendFrame(1'b0, 32'h0000_1234, 32'h0000_0001, 32'h03FF_FFFF, "bp");
    check("bp_beats", 64'(accepts - acc0), 64'(4));
    rdyMode = 0;

    // Simultaneous ready, twice, to see alternation.
    sendBoth(32'hAAAA_0001, 32'hBBBB_0001, "both1");
    sendBoth(32'hAAAA_0002, 32'hBBBB_0002, "both2");

    // Held latch: no resend while the flag stays high.
    setData(1'b0, 32'hC0DE_0001, 32'h0000_0042, 32'h0012_3456);
    @(posedge globalClock); #1;
    pushFrame(1'b0, 32'hC0DE_0001, 32'h0000_0042, 32'h0012_3456, mSeq1);
    iRdy1 = 1'b1;
    waitPulse(1'b0, "held_pulse");
    bumpSeq(1'b0);
    heldValid = 0;
    repeat (50) begin
      @(negedge globalClock);
      if (oValid) heldValid++;
    end
    check("held_novalid", 64'(heldValid), 64'(0));
    iRdy1 = 1'b0;
    settle("held");
    sendFrame(1'b0, 32'hC0DE_0002, 32'h0000_0043, 32'h0000_0001, "rearm");

    // Sequence wrap on channel 1.
    @(posedge globalClock); #1;
    force dut.seq1 = 16'hFFFF;
    @(posedge globalClock); #1;
    release dut.seq1;
    mSeq1 = 16'hFFFF;
    sendFrame(1'b0, 32'h1111_0000, 32'h2222_0000, 32'h0000_0ABC, "wrapF");
    sendFrame(1'b0, 32'h1111_0001, 32'h2222_0001, 32'h0000_0ABD, "wrap0");

    // Reset during the HI beat.
    rdyMode = 2;
    @(posedge globalClock); #1;
    iReady = 1'b0;
    setData(1'b0, 32'h5555_0000, 32'h6666_0000, 32'h0077_7777);
    pushFrame(1'b0, 32'h5555_0000, 32'h6666_0000, 32'h0077_7777, mSeq1);
    iRdy1 = 1'b1;
    for (int i = 0; i < 20 && !oValid; i++) @(negedge globalClock);
    check("mid_valid", 64'(oValid), 64'(1));
    @(posedge globalClock); #1;
    iReady = 1'b1;
    @(posedge globalClock); #1;
    iReady = 1'b1;
    @(posedge globalClock); #1;
    iReady = 1'b0;
    check("mid_hi", 64'(oData), 64'(32'h6666_0000));
    iReset = 1'b1;
    #1;
    check("mid_rst", 64'({oValid, oResetLatch1, oData}), 64'(0));
    void'(expQ.pop_front());
    void'(expQ.pop_front());
    mSeq1 = '0; mSeq2 = '0; mPtr = 1'b0;
    pushFrame(1'b0, 32'h5555_0000, 32'h6666_0000, 32'h0077_7777, mSeq1);
    repeat (3) @(posedge globalClock);
    #1;
    iReset = 1'b0;
    rdyMode = 0;
    waitPulse(1'b0, "mid_pulse");
    bumpSeq(1'b0);
    iRdy1 = 1'b0;
    settle("mid");

    check("rl1_total", 64'(rl1Cycles), 64'(expRl1));
    check("rl2_total", 64'(rl2Cycles), 64'(expRl2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
